id_branch_operand_resolver: RTL and testbench

- Parametrised successor to the ID-stage branch forwarding logic.
- Resolves branch and JALR source operands in ID by forwarding from MEM and WB.
- Detects operands that cannot be forwarded yet: an ALU producer still in EX, or a load in MEM. Raises a pipeline stall for those.
- Tracks stall episodes with a small FSM, a watchdog error flag and saturating performance counters.
- Sits between the register file read in ID and the branch comparator / JALR target adder. Drives the stall input of the hazard/PC control.

---
 rtl/id_branch_operand_resolver_pkg.sv | 16 +
 rtl/id_branch_operand_resolver_src_resolve.sv | 54 +++++
 rtl/id_branch_operand_resolver.sv | 145 ++++++++++++++
 tb/tb_id_branch_operand_resolver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_branch_operand_resolver_pkg.sv
// Shared constants and types for the ID-stage branch operand resolver.
package id_branch_operand_resolver_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        STALLING = 1'b1
    } stallState_t;

endpackage

// File: rtl/id_branch_operand_resolver_src_resolve.sv
// Single-source hazard detection, forward select and operand mux.
module id_src_resolve
    import id_branch_operand_resolver_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              srcUsed,
    input  logic [REG_AW-1:0] srcReg,
    input  logic [XLEN-1:0]   rfData,
    input  logic              EX_cntl_RegWrite,
    input  logic [REG_AW-1:0] EX_WriteRegNum,
    input  logic              MEM_cntl_RegWrite,
    input  logic              MEM_cntl_MemRead,
    input  logic [REG_AW-1:0] MEM_WriteRegNum,
    input  logic [XLEN-1:0]   MEM_ALUResult,
    input  logic              WB_cntl_RegWrite,
    input  logic [REG_AW-1:0] WB_WriteRegNum,
    input  logic [XLEN-1:0]   WB_WriteData,
    output logic              hazard,
    output logic [1:0]        fwdSel,
    output logic [XLEN-1:0]   operand
);

    logic srcNonZero;
    logic exMatch;
    logic memMatch;
    logic wbMatch;

    // x0 is hardwired, so a nonzero source also guarantees a nonzero producer dest
    assign srcNonZero = (srcReg != '0);
    assign exMatch    = srcNonZero && EX_cntl_RegWrite  && (EX_WriteRegNum  == srcReg);
    assign memMatch   = srcNonZero && MEM_cntl_RegWrite && (MEM_WriteRegNum == srcReg);
    assign wbMatch    = srcNonZero && WB_cntl_RegWrite  && (WB_WriteRegNum  == srcReg);

    // EX results and MEM load data are not yet available to ID
    assign hazard = srcUsed && (exMatch || (memMatch && MEM_cntl_MemRead));

    // pick the youngest available value; MEM ALU result beats WB
    always_comb begin
        fwdSel  = FWD_RF;
        operand = rfData;
        if (srcUsed) begin
            if (memMatch && !MEM_cntl_MemRead) begin
                fwdSel  = FWD_MEM;
                operand = MEM_ALUResult;
            end else if (wbMatch) begin
                fwdSel  = FWD_WB;
                operand = WB_WriteData;
            end
        end
    end

endmodule

// File: rtl/id_branch_operand_resolver.sv
// ID-stage branch/JALR operand resolver with stall watchdog and perf counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no stall last cycle, scnt = 0
// STALLING | consecutive stall cycles in progress, scnt counts them
module id_branch_operand_resolver
    import id_branch_operand_resolver_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 2,
    parameter int REG_AW    = 5,
    parameter int JALR_FWD  = 1,
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ID_valid,
    input  logic [6:0]                ID_opcode,
    input  logic [NUM_SRC*REG_AW-1:0] ID_ReadRegNum,
    input  logic [NUM_SRC*XLEN-1:0]   ID_ReadData,
    input  logic                      EX_cntl_RegWrite,
    input  logic [REG_AW-1:0]         EX_WriteRegNum,
    input  logic                      MEM_cntl_RegWrite,
    input  logic                      MEM_cntl_MemRead,
    input  logic [REG_AW-1:0]         MEM_WriteRegNum,
    input  logic [XLEN-1:0]           MEM_ALUResult,
    input  logic                      WB_cntl_RegWrite,
    input  logic [REG_AW-1:0]         WB_WriteRegNum,
    input  logic [XLEN-1:0]           WB_WriteData,
    output logic [NUM_SRC*2-1:0]      Forward,
    output logic [NUM_SRC*XLEN-1:0]   ID_Operand,
    output logic                      Stall,
    output logic                      stall_err,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          fwd_events
);

    localparam int          SCNT_W    = $clog2(MAX_STALL + 2);
    localparam logic [SCNT_W-1:0] SCNT_SAT  = SCNT_W'(MAX_STALL + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(MAX_STALL);
    localparam bit          ERR_ON_FIRST = (MAX_STALL == 0);

    logic               isBranch;
    logic               isJalr;
    logic [NUM_SRC-1:0] srcUsed;
    logic [NUM_SRC-1:0] srcHazard;
    logic               fwdResolved;

    stallState_t        stState;
    logic [SCNT_W-1:0]  scnt;

    assign isBranch = ID_valid && (ID_opcode == OP_BRANCH);
    assign isJalr   = ID_valid && (JALR_FWD != 0) && (ID_opcode == OP_JALR);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            // JALR only reads rs1, which sits in source slot 0
            if (gi == 0) begin : g_slot0
                assign srcUsed[gi] = isBranch || isJalr;
            end else begin : g_slotN
                assign srcUsed[gi] = isBranch;
            end

            id_src_resolve #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW)
            ) u_src (
                .srcUsed           (srcUsed[gi]),
                .srcReg            (ID_ReadRegNum[gi*REG_AW +: REG_AW]),
                .rfData            (ID_ReadData[gi*XLEN +: XLEN]),
                .EX_cntl_RegWrite  (EX_cntl_RegWrite),
                .EX_WriteRegNum    (EX_WriteRegNum),
                .MEM_cntl_RegWrite (MEM_cntl_RegWrite),
                .MEM_cntl_MemRead  (MEM_cntl_MemRead),
                .MEM_WriteRegNum   (MEM_WriteRegNum),
                .MEM_ALUResult     (MEM_ALUResult),
                .WB_cntl_RegWrite  (WB_cntl_RegWrite),
                .WB_WriteRegNum    (WB_WriteRegNum),
                .WB_WriteData      (WB_WriteData),
                .hazard            (srcHazard[gi]),
                .fwdSel            (Forward[gi*2 +: 2]),
                .operand           (ID_Operand[gi*XLEN +: XLEN])
            );
        end
    endgenerate

    assign Stall = |srcHazard;

    // unused sources always select FWD_RF, so any nonzero select means a real forward
    assign fwdResolved = (|srcUsed) && !Stall && (|Forward);

    // stall-episode tracker; flags episodes longer than MAX_STALL cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stState   <= RUN;
            scnt      <= '0;
            stall_err <= 1'b0;
        end else begin
            case (stState)
                RUN: begin
                    if (Stall) begin
                        stState <= STALLING;
                        scnt    <= SCNT_W'(1);
                        if (ERR_ON_FIRST) stall_err <= 1'b1;
                    end
                end
                STALLING: begin
                    if (Stall) begin
                        if (scnt != SCNT_SAT) scnt <= scnt + SCNT_W'(1);
                        if (scnt >= SCNT_LAST) stall_err <= 1'b1;
                    end else begin
                        stState <= RUN;
                        scnt    <= '0;
                    end
                end
                default: begin
                    stState <= RUN;
                    scnt    <= '0;
                end
            endcase
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (Stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // saturating count of resolved branches that used a forward
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_events <= '0;
        end else if (fwdResolved && (fwd_events != '1)) begin
            fwd_events <= fwd_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_branch_operand_resolver.sv
// Directed-vector bench for id_branch_operand_resolver (JALR_FWD=1 and JALR_FWD=0 builds).
module tb_id_branch_operand_resolver;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_valid;
    logic [6:0]  ID_opcode;
    logic [9:0]  ID_ReadRegNum;
    logic [63:0] ID_ReadData;
    logic        EX_cntl_RegWrite;
    logic [4:0]  EX_WriteRegNum;
    logic        MEM_cntl_RegWrite;
    logic        MEM_cntl_MemRead;
    logic [4:0]  MEM_WriteRegNum;
    logic [31:0] MEM_ALUResult;
    logic        WB_cntl_RegWrite;
    logic [4:0]  WB_WriteRegNum;
    logic [31:0] WB_WriteData;

    logic [3:0]  Forward,  Forward0;
    logic [63:0] ID_Operand, ID_Operand0;
    logic        Stall, Stall0;
    logic        stall_err, stall_err0;
    logic [31:0] stall_cycles, stall_cycles0;
    logic [31:0] fwd_events, fwd_events0;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    id_branch_operand_resolver dut (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
        .ID_ReadRegNum(ID_ReadRegNum), .ID_ReadData(ID_ReadData),
        .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_WriteRegNum(EX_WriteRegNum),
        .MEM_cntl_RegWrite(MEM_cntl_RegWrite), .MEM_cntl_MemRead(MEM_cntl_MemRead),
        .MEM_WriteRegNum(MEM_WriteRegNum), .MEM_ALUResult(MEM_ALUResult),
        .WB_cntl_RegWrite(WB_cntl_RegWrite), .WB_WriteRegNum(WB_WriteRegNum),
        .WB_WriteData(WB_WriteData), .Forward(Forward), .ID_Operand(ID_Operand),
        .Stall(Stall), .stall_err(stall_err), .stall_cycles(stall_cycles),
        .fwd_events(fwd_events)
    );

    id_branch_operand_resolver #(.JALR_FWD(0)) dutNoJalr (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
        .ID_ReadRegNum(ID_ReadRegNum), .ID_ReadData(ID_ReadData),
        .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_WriteRegNum(EX_WriteRegNum),
        .MEM_cntl_RegWrite(MEM_cntl_RegWrite), .MEM_cntl_MemRead(MEM_cntl_MemRead),
        .MEM_WriteRegNum(MEM_WriteRegNum), .MEM_ALUResult(MEM_ALUResult),
        .WB_cntl_RegWrite(WB_cntl_RegWrite), .WB_WriteRegNum(WB_WriteRegNum),
        .WB_WriteData(WB_WriteData), .Forward(Forward0), .ID_Operand(ID_Operand0),
        .Stall(Stall0), .stall_err(stall_err0), .stall_cycles(stall_cycles0),
        .fwd_events(fwd_events0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; return 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearPipe();
        EX_cntl_RegWrite  = 1'b0; EX_WriteRegNum  = '0;
        MEM_cntl_RegWrite = 1'b0; MEM_cntl_MemRead = 1'b0;
        MEM_WriteRegNum   = '0;   MEM_ALUResult   = '0;
        WB_cntl_RegWrite  = 1'b0; WB_WriteRegNum  = '0; WB_WriteData = '0;
    endtask

    task automatic setId(input logic v, input logic [6:0] op, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [31:0] d0, input logic [31:0] d1);
        ID_valid      = v;
        ID_opcode     = op;
        ID_ReadRegNum = {r1, r0};
        ID_ReadData   = {d1, d0};
    endtask

    initial begin
        reset = 1'b1;
        clearPipe();
        setId(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_fwd_events", fwd_events, 0);
        chk("rst_stall_err", stall_err, 0);
        chk("rst_stall", Stall, 0);
        reset = 1'b0;

        // MEM forward on src0, WB forward on src1
        setId(1'b1, BR, 5'd5, 5'd6, 32'h55, 32'h66);
        MEM_cntl_RegWrite = 1'b1; MEM_WriteRegNum = 5'd5; MEM_ALUResult = 32'hAAAA;
        WB_cntl_RegWrite  = 1'b1; WB_WriteRegNum  = 5'd6; WB_WriteData  = 32'h1234;
        #1;
        chk("t1_forward", Forward, 4'b0110);
        chk("t1_operand", ID_Operand, {32'h1234, 32'hAAAA});
        chk("t1_stall", Stall, 0);
        step();
        chk("t1_fwd_events", fwd_events, 1);

        // MEM beats WB; x0 never forwards or stalls
        clearPipe();
        setId(1'b1, BR, 5'd7, 5'd0, 32'h77, 32'h99);
        EX_cntl_RegWrite  = 1'b1; EX_WriteRegNum  = 5'd0;
        MEM_cntl_RegWrite = 1'b1; MEM_WriteRegNum = 5'd7; MEM_ALUResult = 32'h1;
        WB_cntl_RegWrite  = 1'b1; WB_WriteRegNum  = 5'd7; WB_WriteData  = 32'h2;
        #1;
        chk("t2_forward", Forward, 4'b0010);
        chk("t2_operand", ID_Operand, {32'h99, 32'h1});
        chk("t2_stall", Stall, 0);
        step();
        chk("t2_fwd_events", fwd_events, 2);

        // ALU producer in EX: one stall, then MEM forward
        clearPipe();
        setId(1'b1, BR, 5'd3, 5'd1, 32'h33, 32'h11);
        EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd3;
        #1;
        chk("t3_stall_ex", Stall, 1);
        chk("t3_forward_ex", Forward, 4'b0000);
        step();
        chk("t3_stall_cycles", stall_cycles, 1);
        clearPipe();
        MEM_cntl_RegWrite = 1'b1; MEM_WriteRegNum = 5'd3; MEM_ALUResult = 32'h3000;
        #1;
        chk("t3_stall_mem", Stall, 0);
        chk("t3_forward_mem", Forward, 4'b0010);
        chk("t3_operand_mem", ID_Operand, {32'h11, 32'h3000});
        step();
        chk("t3_stall_cycles_after", stall_cycles, 1);
        chk("t3_fwd_events", fwd_events, 3);

        // load producer: EX stall, MEM-load stall, then WB forward
        clearPipe();
        setId(1'b1, BR, 5'd4, 5'd2, 32'h44, 32'h22);
        EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd4;
        #1;
        chk("t4_stall_ex", Stall, 1);
        step();
        clearPipe();
        MEM_cntl_RegWrite = 1'b1; MEM_cntl_MemRead = 1'b1; MEM_WriteRegNum = 5'd4;
        MEM_ALUResult = 32'hDEAD;
        #1;
        chk("t4_stall_load", Stall, 1);
        chk("t4_forward_load", Forward, 4'b0000);
        step();
        chk("t4_stall_cycles", stall_cycles, 3);
        clearPipe();
        WB_cntl_RegWrite = 1'b1; WB_WriteRegNum = 5'd4; WB_WriteData = 32'h4444;
        #1;
        chk("t4_stall_wb", Stall, 0);
        chk("t4_forward_wb", Forward, 4'b0001);
        chk("t4_operand_wb", ID_Operand, {32'h22, 32'h4444});
        step();
        chk("t4_fwd_events", fwd_events, 4);
        chk("t4_stall_err", stall_err, 0);

        // watchdog: 4 consecutive stall cycles with MAX_STALL=3
        clearPipe();
        setId(1'b1, BR, 5'd8, 5'd2, 32'h88, 32'h22);
        EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd8;
        for (int i = 0; i < 3; i++) step();
        chk("t5_err_after3", stall_err, 0);
        chk("t5_stall_cycles3", stall_cycles, 6);
        step();
        chk("t5_err_after4", stall_err, 1);
        chk("t5_stall_cycles4", stall_cycles, 7);
        clearPipe();
        setId(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        chk("t5_err_sticky", stall_err, 1);

        // reset while a hazard is present
        setId(1'b1, BR, 5'd8, 5'd2, 32'h88, 32'h22);
        EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd8;
        reset = 1'b1;
        step();
        chk("t5_rst_stall_cycles", stall_cycles, 0);
        chk("t5_rst_fwd_events", fwd_events, 0);
        chk("t5_rst_err", stall_err, 0);
        chk("t5_rst_stall_comb", Stall, 1);
        reset = 1'b0;
        clearPipe();
        setId(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        chk("t5_idle_stall_cycles", stall_cycles, 0);

        // JALR: src0 only with JALR_FWD=1, ignored with JALR_FWD=0
        clearPipe();
        setId(1'b1, JALR, 5'd9, 5'd10, 32'h90, 32'hA0);
        MEM_cntl_RegWrite = 1'b1; MEM_WriteRegNum = 5'd9; MEM_ALUResult = 32'h9999;
        EX_cntl_RegWrite  = 1'b1; EX_WriteRegNum  = 5'd10;
        #1;
        chk("t6_jalr_forward", Forward, 4'b0010);
        chk("t6_jalr_stall", Stall, 0);
        chk("t6_jalr_operand", ID_Operand, {32'hA0, 32'h9999});
        chk("t6_nojalr_forward", Forward0, 4'b0000);
        chk("t6_nojalr_stall", Stall0, 0);
        chk("t6_nojalr_operand", ID_Operand0, {32'hA0, 32'h90});
        step();
        chk("t6_fwd_events", fwd_events, 1);
        chk("t6_nojalr_fwd_events", fwd_events0, 0);

        // same register on both sources
        clearPipe();
        setId(1'b1, BR, 5'd11, 5'd11, 32'h1, 32'h2);
        MEM_cntl_RegWrite = 1'b1; MEM_WriteRegNum = 5'd11; MEM_ALUResult = 32'hBB;
        #1;
        chk("t7_same_forward", Forward, 4'b1010);
        chk("t7_same_operand", ID_Operand, {32'hBB, 32'hBB});
        step();
        chk("t7_fwd_events", fwd_events, 2);

        // hazard on src0 with forward on src1: stall wins, no fwd event
        clearPipe();
        setId(1'b1, BR, 5'd12, 5'd13, 32'hC, 32'hD);
        EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd12;
        WB_cntl_RegWrite = 1'b1; WB_WriteRegNum = 5'd13; WB_WriteData = 32'h1313;
        #1;
        chk("t8_mixed_stall", Stall, 1);
        chk("t8_mixed_forward", Forward, 4'b0100);
        step();
        chk("t8_mixed_fwd_events", fwd_events, 2);
        chk("t8_mixed_stall_cycles", stall_cycles, 1);

        // non-branch opcode and invalid slot use no sources
        setId(1'b1, ALU, 5'd12, 5'd13, 32'hC, 32'hD);
        #1;
        chk("t9_alu_stall", Stall, 0);
        chk("t9_alu_forward", Forward, 4'b0000);
        chk("t9_alu_operand", ID_Operand, {32'hD, 32'hC});
        setId(1'b0, BR, 5'd12, 5'd13, 32'hC, 32'hD);
        #1;
        chk("t9_invalid_stall", Stall, 0);
        chk("t9_invalid_forward", Forward, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
